// File: rtl/light_pkg.sv
// Shared constants and types for the holiday-lights input front end and pattern engine.
package light_pkg;
  localparam int CLK_HZ          = 100_000_000;
  localparam int DB_CYCLES_DEF   = 2_000_000;   // 20 ms at CLK_HZ
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {DB_STABLE, DB_COUNT} db_state_e;
endpackage

// File: rtl/light_input_conditioner_debounce_bit.sv
// One input line: synchroniser, debounce FSM and stable register with commit strobes.
module debounce_bit
  import light_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic [CW-1:0]          cnt;
  db_state_e              state;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync   <= '0;
      state  <= DB_STABLE;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        DB_STABLE: begin
          cnt <= '0;
          if (synced != stable) begin
            cnt   <= CW'(1);
            state <= DB_COUNT;
          end
        end
        DB_COUNT: begin
          if (synced == stable) begin
            cnt   <= '0;
            state <= DB_STABLE;
          end else if (cnt == CW'(DB_CYCLES - 1)) begin
            // enough consecutive disagreeing samples: commit the new level
            stable <= synced;
            rise   <= synced;
            fall   <= ~synced;
            cnt    <= '0;
            state  <= DB_STABLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= DB_STABLE;
        end
      endcase
    end
  end
endmodule

// File: rtl/light_input_conditioner.sv
// Debounces the push-button and DIP switches; emits press pulse, run enable toggle and switch change strobe.
module light_input_conditioner
  import light_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [2:0] switch,
  output logic       button_level,
  output logic       press_pulse,
  output logic       run_en,
  output logic [2:0] switch_stable,
  output logic       switch_changed
);
  localparam int          NUM_LINES = 4;
  localparam logic [3:0]  SW_MASK   = 4'b1110;  // line 0 is the button

  logic [NUM_LINES-1:0] lines, stab, rise, fall, commit;

  assign lines  = {switch, button};
  assign commit = rise | fall;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    debounce_bit #(
      .DB_CYCLES  (DB_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .din   (lines[i]),
      .stable(stab[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      button_level   <= 1'b0;
      press_pulse    <= 1'b0;
      run_en         <= 1'b0;
      switch_stable  <= '0;
      switch_changed <= 1'b0;
    end else begin
      button_level   <= stab[0];
      press_pulse    <= rise[0];
      if (rise[0]) run_en <= ~run_en;
      switch_stable  <= stab[3:1];
      switch_changed <= |(commit & SW_MASK);
    end
  end
endmodule

// File: doc/light_input_conditioner.md
Name: light_input_conditioner

Overview:
- Front-end stage directly upstream of the holiday-lights LED pattern engine.
- Takes the raw board push-button and 3-bit DIP switch, synchronises and debounces each line, and emits clean signals to the pattern engine:
  - a debounced button level;
  - a one-cycle press pulse;
  - a run enable that toggles on each press;
  - a debounced switch value with a one-cycle change strobe.

Parameters:
- DB_CYCLES, 2_000_000: consecutive stable sampled cycles required before a line's debounced value commits (20 ms at 100 MHz).
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (minimum 2).

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-low reset
- button  input  1  raw push-button, asynchronous to clk, active-high
- switch  input  3  raw DIP switches, asynchronous to clk
- button_level  output  1  debounced button level
- press_pulse  output  1  one-cycle strobe on debounced button 0->1
- run_en  output  1  toggles on every press_pulse; feeds the pattern engine's enable
- switch_stable  output  3  debounced switch value
- switch_changed  output  1  one-cycle strobe when any switch_stable bit commits a new value

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- While rst=0, all of the following are 0: synchroniser flops, counters, stable values, and every output.
- Synchronisers:
  - Each of the 4 inputs passes through SYNC_STAGES flops.
  - Debounce logic uses only the last stage, called "synced".
- Per-line debounce FSM (4 independent instances, one per line):
  - STABLE: synced == stable, counter held at 0. If synced != stable, go to COUNT with counter=1.
  - COUNT:
    - If synced == stable: counter <= 0, go to STABLE. The glitch is rejected and no output changes.
    - Else if counter == DB_CYCLES-1: stable <= synced, counter <= 0, go to STABLE. This is the commit.
    - Else: counter += 1.
  - Counter width is $clog2(DB_CYCLES+1). The counter never wraps.
- Latency:
  - A clean input edge sampled at clock N is committed to stable at clock N + SYNC_STAGES + DB_CYCLES - 1.
  - The edge is visible on the outputs from the following cycle.
  - Pulses shorter than DB_CYCLES sampled cycles are fully rejected.
- Button outputs:
  - button_level equals the button line's stable value.
  - press_pulse=1 for exactly one cycle, in the cycle after the stable value commits 0->1.
  - A 1->0 commit produces no pulse.
  - run_en flips in the same edge that raises press_pulse, so run_en changes coincide with press_pulse=1.
- Switch outputs:
  - switch_stable[i] equals the stable value of switch line i.
  - switch_changed=1 for one cycle after any bit commits.
  - Several bits committing in the same cycle produce a single pulse.
  - Bits committing in different cycles produce separate pulses.
- Independence: button and switch lines are fully independent. Simultaneous activity on all lines must not interact.
- Reset release with inputs already asserted:
  - The reset state is 0, so a button held through reset is treated as a new press: press_pulse fires after the full latency.
  - Likewise, nonzero switches produce switch_changed after the full latency. This gives the pattern engine its initial configuration.
- Reset mid-count: the count is discarded immediately (asynchronous). No pulse is emitted for the interrupted count.
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Shared package light_pkg:
  - DB_CYCLES default;
  - SYNC_STAGES default;
  - a localparam for CLK_HZ = 100_000_000, also used by the pattern engine's one-second tick.
- One sub-module, debounce_bit:
  - contents: synchroniser, counter/FSM, stable register;
  - outputs: stable and a one-cycle rise/fall commit strobe;
  - instantiated 4 times.
- The top level holds:
  - press_pulse logic;
  - the run_en toggle;
  - the OR-reduction that forms switch_changed.

Test Plan:
All scenarios use DB_CYCLES=8 and SYNC_STAGES=2.
- Reset with all inputs 0, run 100 cycles -> all outputs stay 0, no pulses.
- Raise button at edge 0 and hold -> button_level=1 and press_pulse=1 for one cycle at edge 10; run_en goes 0->1 at the same edge; no further pulses while held.
- Button high for 5 cycles then low (bounce) -> no press_pulse, button_level stays 0, run_en unchanged. Repeat with a 7-cycle glitch -> still rejected.
- Switch 000->101 at edge 0 and hold -> switch_stable=101 and a single switch_changed pulse at edge 10. Then bit 1 goes high 3 cycles later -> a second separate pulse, switch_stable=111.
- Full press, release, press again -> run_en sequence 0->1->0. The release commit produces no press_pulse.
- Assert rst at cycle 6 of a button count -> outputs 0 immediately. Release rst with button still high -> press_pulse exactly 10 cycles after release, run_en=1.
